// File: rtl/tweetboard_ram_sched.sv
// Message-RAM port scheduler: clear sweep, serial store path and playback reads share one RAM port.
// Optional feature: define TWB_BACKSPACE_EN so that 8'h08 deletes the last stored character.
`timescale 1ns/1ps
module tweetboard_ram_sched #(
    parameter int ADDR_W    = 8,
    parameter int MAX_CHARS = 160
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              clr_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              play_start,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              busy,
    output logic              full
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_WRITE = 3'd2,
        S_FETCH = 3'd3,
        S_WAIT  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] MAX_PTR   = ADDR_W'(MAX_CHARS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ZERO      = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE       = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] wr_ptr_r;
    logic [ADDR_W-1:0] play_ptr_r;
    logic [ADDR_W-1:0] clr_addr_r;
    logic [7:0]        tx_data_r;
    logic              ret_hold_r;
    logic              is_bs_s;
    logic              do_store_s;
    logic              do_erase_s;
    logic              play_end_s;
    logic              rdata_unused_s;

`ifdef TWB_BACKSPACE_EN
    assign is_bs_s = (rx_data == 8'h08);
`else
    assign is_bs_s = 1'b0;
`endif
    assign do_store_s     = !is_bs_s && (wr_ptr_r != MAX_PTR);
    assign do_erase_s     = is_bs_s && (wr_ptr_r != ZERO);
    assign play_end_s     = !ram_rdata[15] || (play_ptr_r == MAX_PTR);
    assign rdata_unused_s = ^ram_rdata[14:8];

    // State register
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: clr_start wins in IDLE and aborts playback; tx_ready beats rx_valid in HOLD
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (clr_start)       state_next_s = S_CLEAR;
                else if (rx_valid)   state_next_s = S_WRITE;
                else if (play_start) state_next_s = S_FETCH;
                else                 state_next_s = S_IDLE;
            end
            S_CLEAR: begin
                if (clr_addr_r == LAST_ADDR) state_next_s = S_IDLE;
                else                         state_next_s = S_CLEAR;
            end
            S_WRITE: begin
                if (ret_hold_r) state_next_s = S_HOLD;
                else            state_next_s = S_IDLE;
            end
            S_FETCH: begin
                if (clr_start) state_next_s = S_CLEAR;
                else           state_next_s = S_WAIT;
            end
            S_WAIT: begin
                if (clr_start)       state_next_s = S_CLEAR;
                else if (play_end_s) state_next_s = S_IDLE;
                else                 state_next_s = S_HOLD;
            end
            S_HOLD: begin
                if (clr_start)     state_next_s = S_CLEAR;
                else if (tx_ready) state_next_s = S_FETCH;
                else if (rx_valid) state_next_s = S_WRITE;
                else               state_next_s = S_HOLD;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Pointers, clear sweep address, WRITE return flag and the byte on offer
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_ptr_r   <= ZERO;
            play_ptr_r <= ZERO;
            clr_addr_r <= ZERO;
            tx_data_r  <= 8'h00;
            ret_hold_r <= 1'b0;
        end else begin
            clr_addr_r <= (state_r == S_CLEAR) ? clr_addr_r + ONE : ZERO;
            if (state_next_s == S_WRITE) ret_hold_r <= (state_r == S_HOLD);
            else                         ret_hold_r <= ret_hold_r;
            if (state_r == S_WRITE) begin
                if (do_erase_s)      wr_ptr_r <= wr_ptr_r - ONE;
                else if (do_store_s) wr_ptr_r <= wr_ptr_r + ONE;
                else                 wr_ptr_r <= wr_ptr_r;
            end else if (state_r == S_CLEAR && clr_addr_r == LAST_ADDR) begin
                wr_ptr_r <= ZERO;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (state_r == S_IDLE && state_next_s == S_FETCH)      play_ptr_r <= ZERO;
            else if (state_r == S_HOLD && state_next_s == S_FETCH) play_ptr_r <= play_ptr_r + ONE;
            else                                                   play_ptr_r <= play_ptr_r;
            if (state_r == S_WAIT && state_next_s == S_HOLD) tx_data_r <= ram_rdata[7:0];
            else                                             tx_data_r <= tx_data_r;
        end
    end

    // RAM port and handshake outputs decoded from state and pointers
    always_comb begin
        ram_addr  = ZERO;
        ram_we    = 1'b0;
        ram_wdata = 16'h0000;
        rx_ready  = 1'b0;
        case (state_r)
            S_CLEAR: begin
                ram_addr = clr_addr_r;
                ram_we   = 1'b1;
            end
            S_WRITE: begin
                rx_ready = 1'b1;
                if (do_erase_s) begin
                    ram_we   = 1'b1;
                    ram_addr = wr_ptr_r - ONE;
                end else if (do_store_s) begin
                    ram_we    = 1'b1;
                    ram_addr  = wr_ptr_r;
                    ram_wdata = {1'b1, 7'b0000000, rx_data};
                end else begin
                    ram_addr = wr_ptr_r;
                end
            end
            S_FETCH: ram_addr = play_ptr_r;
            default: ram_we = 1'b0;
        endcase
    end

    assign tx_valid = (state_r == S_HOLD) || (state_r == S_WRITE && ret_hold_r);
    assign tx_data  = tx_data_r;
    assign wr_ptr   = wr_ptr_r;
    assign busy     = (state_r != S_IDLE);
    assign full     = (wr_ptr_r == MAX_PTR);
endmodule

// File: tb/tb_tweetboard_ram_sched.sv
// Bench for tweetboard_ram_sched: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against an activity-level model of the scheduler.
`timescale 1ns/1ps
module tb_tweetboard_ram_sched;
    localparam int ADDR_W    = 8;
    localparam int MAX_CHARS = 160;
    localparam int DEPTH     = 256;

    logic              sysclk     = 1'b0;
    logic              reset      = 1'b1;
    logic              clr_start  = 1'b0;
    logic              rx_valid   = 1'b0;
    logic [7:0]        rx_data    = 8'h00;
    logic              play_start = 1'b0;
    logic              tx_ready   = 1'b0;
    logic              rx_ready, tx_valid, ram_we, busy, full;
    logic [7:0]        tx_data;
    logic [ADDR_W-1:0] ram_addr, wr_ptr;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata  = 16'h0000;
    logic [15:0]       ram [DEPTH];

    int errors = 0;
    int checks = 0;

    tweetboard_ram_sched #(.ADDR_W(ADDR_W), .MAX_CHARS(MAX_CHARS)) dut (
        .sysclk(sysclk), .reset(reset), .clr_start(clr_start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .play_start(play_start), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .wr_ptr(wr_ptr), .busy(busy), .full(full)
    );

    always #5 sysclk = ~sysclk;

    // Synchronous RAM with one-cycle read latency
    always @(posedge sysclk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_bs(input logic [7:0] b);
`ifdef TWB_BACKSPACE_EN
        return (b == 8'h08);
`else
        return 1'b0;
`endif
    endfunction

    // Model: what the block is doing, described as activities rather than states
    int          m_clear_left = 0;   // clear-sweep cycles still to run
    bit          m_store      = 1'b0; // this cycle accepts the pending rx byte
    bit          m_play       = 1'b0; // a playback is in progress
    int          m_gap        = 0;   // cycles until the current byte is offered (0 = offered)
    int          m_idx        = 0;   // message index being played
    int          m_wp         = 0;   // stored character count
    logic [7:0]  m_txd        = 8'h00;
    logic [15:0] mem_m [DEPTH];

    always @(posedge sysclk or posedge reset) begin
        if (reset) begin
            m_clear_left <= 0;
            m_store      <= 1'b0;
            m_play       <= 1'b0;
            m_gap        <= 0;
            m_idx        <= 0;
            m_wp         <= 0;
        end else if (m_clear_left > 0) begin
            mem_m[DEPTH - m_clear_left] <= 16'h0000;
            m_clear_left <= m_clear_left - 1;
            if (m_clear_left == 1) m_wp <= 0;
        end else if (m_store) begin
            m_store <= 1'b0;
            if (is_bs(rx_data)) begin
                if (m_wp > 0) begin
                    mem_m[m_wp - 1] <= 16'h0000;
                    m_wp <= m_wp - 1;
                end
            end else if (m_wp < MAX_CHARS) begin
                mem_m[m_wp] <= {8'h80, rx_data};
                m_wp <= m_wp + 1;
            end
        end else if (m_play) begin
            if (clr_start) begin
                m_play       <= 1'b0;
                m_clear_left <= DEPTH;
            end else if (m_gap == 2) begin
                m_gap <= 1;
            end else if (m_gap == 1) begin
                if (!mem_m[m_idx][15] || m_idx == MAX_CHARS) m_play <= 1'b0;
                else begin
                    m_gap <= 0;
                    m_txd <= mem_m[m_idx][7:0];
                end
            end else if (tx_ready) begin
                m_idx <= m_idx + 1;
                m_gap <= 2;
            end else if (rx_valid) begin
                m_store <= 1'b1;
            end
        end else begin
            if (clr_start)      m_clear_left <= DEPTH;
            else if (rx_valid)  m_store <= 1'b1;
            else if (play_start) begin
                m_play <= 1'b1;
                m_idx  <= 0;
                m_gap  <= 2;
            end
        end
    end

    bit          e_busy, e_we, e_txv;
    int          e_addr;
    logic [15:0] e_wdata;

    always_comb begin
        e_busy  = (m_clear_left > 0) || m_store || m_play;
        e_txv   = m_play && (m_gap == 0);
        e_we    = 1'b0;
        e_addr  = 0;
        e_wdata = 16'h0000;
        if (m_clear_left > 0) begin
            e_we   = 1'b1;
            e_addr = DEPTH - m_clear_left;
        end else if (m_store) begin
            if (is_bs(rx_data)) begin
                if (m_wp > 0) begin
                    e_we   = 1'b1;
                    e_addr = m_wp - 1;
                end
            end else if (m_wp < MAX_CHARS) begin
                e_we    = 1'b1;
                e_addr  = m_wp;
                e_wdata = {8'h80, rx_data};
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge sysclk) begin
        chk("busy", busy, e_busy);
        chk("rx_ready", rx_ready, m_store);
        chk("ram_we", ram_we, e_we);
        chk("wr_ptr", wr_ptr, m_wp);
        chk("full", full, (m_wp == MAX_CHARS));
        chk("tx_valid", tx_valid, e_txv);
        if (e_we) begin
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_wdata", ram_wdata, e_wdata);
        end
        if (!e_busy) chk("idle_addr", ram_addr, 0);
        if (e_txv) chk("tx_data", tx_data, m_txd);
    end

    task automatic do_clear(output int n, output int k);
        @(posedge sysclk); #1;
        clr_start = 1'b1;
        @(posedge sysclk); #1;
        clr_start = 1'b0;
        n = 0;
        k = 0;
        while (k < 400) begin
            @(negedge sysclk);
            if (!busy) break;
            if (ram_we && ram_wdata == 16'h0000 && ram_addr == 8'(n)) n++;
            k++;
        end
        if (k >= 400) chk("clear_timeout", busy, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, output int lat, output int wes,
                             output logic [7:0] waddr, output logic [15:0] wdat, output bit txv_all);
        @(posedge sysclk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        lat = 0; wes = 0; waddr = 8'h00; wdat = 16'h0000; txv_all = 1'b1;
        do begin
            @(negedge sysclk);
            lat++;
            if (ram_we) begin
                wes++;
                waddr = ram_addr;
                wdat  = ram_wdata;
            end
            if (!tx_valid) txv_all = 1'b0;
        end while (!rx_ready && lat < 400);
        if (!rx_ready) chk("rx_accept_timeout", rx_ready, 1'b1);
        @(posedge sysclk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int l, w; logic [7:0] a; logic [15:0] d; bit t;
        send_byte(b, l, w, a, d, t);
    endtask

    task automatic random_play(input bit allow_abort);
        int k; bit rdy_prev; bit txv;
        @(posedge sysclk); #1;
        play_start = 1'b1;
        rdy_prev = 1'b0;
        for (k = 0; k < 3000; k++) begin
            @(negedge sysclk);
            if (k > 0 && !busy && !rx_valid) break;
            rdy_prev = rx_ready;
            txv      = tx_valid;
            @(posedge sysclk); #1;
            play_start = 1'b0;
            clr_start  = 1'b0;
            tx_ready   = ($urandom_range(0, 2) == 0);
            if (rx_valid && rdy_prev) rx_valid = 1'b0;
            else if (!rx_valid && txv && $urandom_range(0, 5) == 0) begin
                rx_valid = 1'b1;
                rx_data  = ($urandom_range(0, 4) == 0) ? 8'h08 : 8'($urandom_range(32, 126));
            end
            if (allow_abort && txv && $urandom_range(0, 30) == 0) clr_start = 1'b1;
        end
        if (k >= 3000) chk("play_timeout", busy, 1'b0);
        tx_ready  = 1'b0;
        clr_start = 1'b0;
    endtask

    task automatic reset_mid();
        int d;
        d = $urandom_range(1, 40);
        @(posedge sysclk); #1;
        if ($urandom_range(0, 1) == 1) play_start = 1'b1;
        else clr_start = 1'b1;
        @(posedge sysclk); #1;
        play_start = 1'b0;
        clr_start  = 1'b0;
        repeat (d) @(posedge sysclk);
        #3 reset = 1'b1;
        @(negedge sysclk);
        chk("reset_mid_wr_ptr", wr_ptr, 0);
        chk("reset_mid_busy", busy, 1'b0);
        @(posedge sysclk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k, t1, t2, nv, lat, wes;
        logic [7:0] d1, d2, wa;
        logic [15:0] wd;
        bit txv_all;

        repeat (3) @(posedge sysclk);
        #1 reset = 1'b0;
        @(negedge sysclk);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);

        do_clear(n, k);
        chk("clear_writes", n, 256);
        chk("clear_cycles", k, 256);
        chk("clear_wr_ptr", wr_ptr, 0);

        send_byte(8'h48, lat, wes, wa, wd, txv_all);
        chk("H_latency", lat - 1, 1);
        chk("H_addr", wa, 0);
        chk("H_data", wd, 16'h8048);
        send_byte(8'h69, lat, wes, wa, wd, txv_all);
        chk("i_addr", wa, 1);
        chk("i_data", wd, 16'h8069);
        chk("Hi_wr_ptr", wr_ptr, 2);
        chk("ram1", ram[1], 16'h8069);

        // Playback with tx_ready tied high
        @(posedge sysclk); #1;
        play_start = 1'b1;
        tx_ready   = 1'b1;
        t1 = -1; t2 = -1; nv = 0; d1 = 8'h00; d2 = 8'h00;
        for (k = 0; k < 50; k++) begin
            @(negedge sysclk);
            if (tx_valid) begin
                nv++;
                if (t1 < 0) begin t1 = k; d1 = tx_data; end
                else if (t2 < 0) begin t2 = k; d2 = tx_data; end
            end
            if (k > 0 && !busy) break;
            @(posedge sysclk); #1;
            play_start = 1'b0;
        end
        tx_ready = 1'b0;
        chk("play_t1", t1, 3);
        chk("play_t2", t2, 6);
        chk("play_d1", d1, 8'h48);
        chk("play_d2", d2, 8'h69);
        chk("play_count", nv, 2);
        chk("play_end_cycle", k, 9);

`ifdef TWB_BACKSPACE_EN
        send_byte(8'h08, lat, wes, wa, wd, txv_all);
        chk("bs_writes", wes, 1);
        chk("bs_addr", wa, 1);
        chk("bs_data", wd, 16'h0000);
        chk("bs_wr_ptr", wr_ptr, 1);
        send_byte(8'h08, lat, wes, wa, wd, txv_all);
        n = wes;
        send_byte(8'h08, lat, wes, wa, wd, txv_all);
        chk("bs2_writes", n + wes, 1);
        chk("bs2_wr_ptr", wr_ptr, 0);
`else
        send_byte(8'h08, lat, wes, wa, wd, txv_all);
        chk("bs_plain_addr", wa, 2);
        chk("bs_plain_data", wd, 16'h8008);
        chk("bs_plain_wr_ptr", wr_ptr, 3);
`endif

        // Fill to the character limit, then one more
        do_clear(n, k);
        for (int i = 0; i < MAX_CHARS; i++) send(8'h61);
        chk("fill_wr_ptr", wr_ptr, 160);
        chk("fill_full", full, 1'b1);
        send_byte(8'h61, lat, wes, wa, wd, txv_all);
        chk("over_latency", lat - 1, 1);
        chk("over_writes", wes, 0);
        chk("over_wr_ptr", wr_ptr, 160);
        random_play(1'b0);

        // Store during HOLD, then abort with clr_start
        do_clear(n, k);
        send(8'h48);
        send(8'h69);
        @(posedge sysclk); #1;
        play_start = 1'b1;
        tx_ready   = 1'b0;
        @(posedge sysclk); #1;
        play_start = 1'b0;
        k = 0;
        while (!tx_valid && k < 20) begin
            @(negedge sysclk);
            k++;
        end
        chk("hold_reached", tx_valid, 1'b1);
        send_byte(8'h78, lat, wes, wa, wd, txv_all);
        chk("hold_rx_addr", wa, 2);
        chk("hold_rx_data", wd, 16'h8078);
        chk("hold_txv_kept", txv_all, 1'b1);
        chk("hold_wr_ptr", wr_ptr, 3);
        clr_start = 1'b1;
        @(negedge sysclk);
        chk("abort_pre_txv", tx_valid, 1'b1);
        @(posedge sysclk); #1;
        clr_start = 1'b0;
        @(negedge sysclk);
        chk("abort_txv", tx_valid, 1'b0);
        chk("abort_clear_we", ram_we, 1'b1);
        k = 0;
        while (busy && k < 300) begin
            @(negedge sysclk);
            k++;
        end
        chk("abort_clear_done", busy, 1'b0);
        chk("abort_wr_ptr", wr_ptr, 0);

        // Randomized traffic
        for (int it = 0; it < 70; it++) begin
            case ($urandom_range(0, 11))
                0:       do_clear(n, k);
                1, 2, 3, 4, 5:
                    send(($urandom_range(0, 3) == 0) ? 8'h08 : 8'($urandom_range(32, 126)));
                6, 7, 8: random_play(1'b1);
                9:       random_play(1'b0);
                10:      reset_mid();
                default: for (int j = 0; j < 12; j++) send(8'($urandom_range(32, 126)));
            endcase
        end

        repeat (3) @(posedge sysclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
